// File: rtl/audio_pkg.sv
// Shared constants and receive-FSM encoding for the codec audio path.
package audio_pkg;

  localparam int AUDIO_SAMPLE_WIDTH = 16;
  localparam int AUDIO_FRAME_BCLKS  = 33;

  // Interface-format register value the configuration block writes to the codec.
  localparam logic [15:0] AUDIO_IFACE_FORMAT = 16'h0E23;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/audio_sample_rx_if.sv
// Left/right sample-pair stream with valid/ready handshake.
interface audio_sample_rx_if
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH
);

  logic signed [SAMPLE_WIDTH-1:0] left_sample;
  logic signed [SAMPLE_WIDTH-1:0] right_sample;
  logic                           sample_valid;
  logic                           sample_ready;

  modport master (
    output left_sample,
    output right_sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left_sample,
    input  right_sample,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/audio_edge_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with a rising-edge strobe.
module audio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_bit,
  output logic synced,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_bit};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~last_q;

endmodule

// File: rtl/audio_sample_rx.sv
// DSP-mode-A codec ADC receiver: oversampled pins -> left/right pair on a valid/ready stream.
// Build option AUDIO_RX_LRSWAP_EN: first half of the frame goes to right_sample instead of left_sample.
module audio_sample_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    BCLK,
  input  logic                    ADC_LR_CLK,
  input  logic                    ADC_DATA,
  audio_sample_rx_if.master       stream,
  output logic                    overrun,
  output logic                    frame_error,
  input  logic                    clear_flags
);

  localparam int FRAME_BITS = 2 * SAMPLE_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  logic                   bclk_s, bclk_rise, lr_s, data_s;
  logic [1:0]             unused_rise;
  rx_state_e              state, next_state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_BITS-1:0]  shreg;
  logic                   do_shift, do_restart, do_load, err_evt, ovr_evt;
  logic [SAMPLE_WIDTH-1:0] first_half, second_half;

  audio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(clk), .reset(reset), .async_bit(BCLK), .synced(bclk_s), .rise(bclk_rise)
  );
  audio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lr (
    .clk(clk), .reset(reset), .async_bit(ADC_LR_CLK), .synced(lr_s), .rise(unused_rise[0])
  );
  audio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .reset(reset), .async_bit(ADC_DATA), .synced(data_s), .rise(unused_rise[1])
  );

  // A sync pulse inside SHIFT is always premature: reaching the full count leaves SHIFT.
  always_comb begin
    next_state = state;
    do_shift   = 1'b0;
    do_restart = 1'b0;
    do_load    = 1'b0;
    err_evt    = 1'b0;
    ovr_evt    = 1'b0;
    case (state)
      HUNT: begin
        if (bclk_rise && lr_s) begin
          next_state = SHIFT;
          do_restart = 1'b1;
        end
      end
      SHIFT: begin
        if (bclk_rise) begin
          if (lr_s) begin
            err_evt    = 1'b1;
            do_restart = 1'b1;
          end else begin
            do_shift = 1'b1;
            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) next_state = LOAD;
          end
        end
      end
      LOAD: begin
        next_state = HUNT;
        if (!stream.sample_valid || stream.sample_ready) do_load = 1'b1;
        else                                             ovr_evt = 1'b1;
      end
      default: next_state = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= HUNT;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state <= next_state;
      if (do_restart) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (do_shift) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {shreg[FRAME_BITS-2:0], data_s};
      end
    end
  end

  assign first_half  = shreg[FRAME_BITS-1:SAMPLE_WIDTH];
  assign second_half = shreg[SAMPLE_WIDTH-1:0];

  // A load in the same cycle as an accept keeps valid high with the new pair.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stream.sample_valid <= 1'b0;
      stream.left_sample  <= '0;
      stream.right_sample <= '0;
      overrun             <= 1'b0;
      frame_error         <= 1'b0;
    end else begin
      if (do_load) begin
        stream.sample_valid <= 1'b1;
`ifdef AUDIO_RX_LRSWAP_EN
        stream.left_sample  <= second_half;
        stream.right_sample <= first_half;
`else
        stream.left_sample  <= first_half;
        stream.right_sample <= second_half;
`endif
      end else if (stream.sample_valid && stream.sample_ready) begin
        stream.sample_valid <= 1'b0;
      end
      if (ovr_evt)          overrun <= 1'b1;
      else if (clear_flags) overrun <= 1'b0;
      if (err_evt)          frame_error <= 1'b1;
      else if (clear_flags) frame_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_sample_rx.sv
// Scoreboard bench for audio_sample_rx: codec bit-stream driver, frame-level reference model, handshake monitor.
`timescale 1ns/1ps
module tb_audio_sample_rx;
  import audio_pkg::*;

  localparam int W = 16;
  localparam int S = 2;

  logic clk = 1'b0, reset = 1'b0, bclk = 1'b0, lr = 1'b0, adc = 1'b0, clear_flags = 1'b0;
  logic overrun, frame_error;

  audio_sample_rx_if #(.SAMPLE_WIDTH(W)) rx();

  audio_sample_rx #(.SAMPLE_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .BCLK(bclk), .ADC_LR_CLK(lr), .ADC_DATA(adc),
    .stream(rx.master), .overrun(overrun), .frame_error(frame_error), .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] sb[$];

  // Reference model state: frame parser over BCLK periods
  bit collecting = 1'b0;
  bit bq[$];
  bit hold = 1'b0;
  bit exp_ferr = 1'b0;
  bit exp_ovr = 1'b0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model_pair();
    logic [W-1:0] a, b;
    a = '0;
    b = '0;
    for (int i = 0; i < W; i++) begin
      a = {a[W-2:0], bq[i]};
      b = {b[W-2:0], bq[W+i]};
    end
    if (hold && sb.size() > 0) exp_ovr = 1'b1;
`ifdef AUDIO_RX_LRSWAP_EN
    else sb.push_back({b, a});
`else
    else sb.push_back({a, b});
`endif
  endfunction

  function automatic void model_feed(input bit lr_v, input bit d);
    if (lr_v) begin
      if (collecting) exp_ferr = 1'b1;
      collecting = 1'b1;
      bq.delete();
    end else if (collecting) begin
      bq.push_back(d);
      if (bq.size() == 2 * W) begin
        model_pair();
        collecting = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) rx.sample_ready = 1'($urandom_range(0, 1));
  endtask

  // One BCLK period of 8 clk; data and frame sync change with the falling edge.
  task automatic send_bit(input bit lr_v, input bit d, input bit lat);
    lr   = lr_v;
    adc  = d;
    bclk = 1'b0;
    repeat (4) tick();
    bclk = 1'b1;
    model_feed(lr_v, d);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (lat && k == S + 1) chk("latency_early", {63'd0, rx.sample_valid}, 64'd0);
      if (lat && k == S + 2) chk("latency_valid", {63'd0, rx.sample_valid}, 64'd1);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] first, input logic [W-1:0] second,
                            input int extra, input bit lat);
    send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = W - 1; i >= 0; i--) send_bit(1'b0, first[i], 1'b0);
    for (int i = W - 1; i >= 0; i--) send_bit(1'b0, second[i], lat && (i == 0));
    for (int i = 0; i < extra; i++) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
    tick();
  endtask

  // Monitor: pops on every accepted pair and checks hold-stability while stalled
  initial begin
    logic [2*W-1:0] held, req;
    bit hold_prev;
    hold_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (hold_prev)
        chk("hold_stable", {31'd0, rx.sample_valid, rx.left_sample, rx.right_sample}, {31'd0, 1'b1, held});
      if (rx.sample_valid === 1'b1 && rx.sample_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pair actual=%0h required=none", {rx.left_sample, rx.right_sample});
        end else begin
          req = sb.pop_front();
          chk("pair", {32'd0, rx.left_sample, rx.right_sample}, {32'd0, req});
        end
      end
      hold_prev = (rx.sample_valid === 1'b1) && (rx.sample_ready === 1'b0);
      held = {rx.left_sample, rx.right_sample};
    end
  end

  initial begin
    rx.sample_ready = 1'b1;
    repeat (3) tick();
    chk("reset_valid", {63'd0, rx.sample_valid}, 64'd0);
    chk("reset_data", {32'd0, rx.left_sample, rx.right_sample}, 64'd0);
    chk("reset_overrun", {63'd0, overrun}, 64'd0);
    chk("reset_ferr", {63'd0, frame_error}, 64'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Single frame, consumer always ready, with latency check
    send_frame(16'hA5C3, 16'h0F0F, 2, 1'b1);
    chk("t1_drained", sb.size(), 0);
    chk("t1_overrun", {63'd0, overrun}, 64'd0);
    chk("t1_ferr", {63'd0, frame_error}, 64'd0);

    // Consumer stalled across two frames
    rx.sample_ready = 1'b0;
    hold = 1'b1;
    send_frame(16'h8001, 16'h7FFF, 1, 1'b0);
    send_frame(16'h1234, 16'hFFFF, 2, 1'b0);
    chk("t3_pending", sb.size(), 1);
    chk("t3_valid", {63'd0, rx.sample_valid}, 64'd1);
    if (sb.size() > 0)
      chk("t3_held_pair", {32'd0, rx.left_sample, rx.right_sample}, {32'd0, sb[0]});
    chk("t3_overrun", {63'd0, overrun}, {63'd0, exp_ovr});
    rx.sample_ready = 1'b1;
    tick();
    rx.sample_ready = 1'b0;
    hold = 1'b0;
    tick();
    chk("t3_valid_drop", {63'd0, rx.sample_valid}, 64'd0);
    chk("t3_drained", sb.size(), 0);
    pulse_clear();
    chk("t3_overrun_clr", {63'd0, overrun}, 64'd0);
    rx.sample_ready = 1'b1;

    // Premature sync after 20 bits, then a good frame
    send_bit(1'b1, 1'b0, 1'b0);
    repeat (20) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    send_frame(16'h0001, 16'h0002, 1, 1'b0);
    repeat (4) tick();
    chk("t4_ferr", {63'd0, frame_error}, {63'd0, exp_ferr});
    chk("t4_drained", sb.size(), 0);
    pulse_clear();
    chk("t4_ferr_clr", {63'd0, frame_error}, 64'd0);

    // Reset in the middle of a frame
    send_bit(1'b1, 1'b1, 1'b0);
    repeat (10) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    reset = 1'b0;
    bclk = 1'b0;
    lr = 1'b0;
    collecting = 1'b0;
    bq.delete();
    repeat (3) tick();
    chk("t5_reset_valid", {63'd0, rx.sample_valid}, 64'd0);
    reset = 1'b1;
    tick();
    send_frame(16'h1111, 16'h2222, 1, 1'b0);
    repeat (2) tick();
    chk("t5_drained", sb.size(), 0);

    // Noise before any sync, then a boundary-value frame
    repeat (40) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    chk("t6_no_valid", {63'd0, rx.sample_valid}, 64'd0);
    send_frame(16'h7FFF, 16'h8000, 1, 1'b0);
    repeat (2) tick();
    chk("t6_drained", sb.size(), 0);

    // Randomized frames, truncated frames and random backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 16; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        repeat ($urandom_range(1, 2 * W - 1)) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      send_frame(W'($urandom), W'($urandom), $urandom_range(0, 3), 1'b0);
    end
    rand_ready = 1'b0;
    rx.sample_ready = 1'b1;
    repeat (10) tick();
    chk("rand_drained", sb.size(), 0);
    chk("rand_ferr", {63'd0, frame_error}, {63'd0, exp_ferr});
    chk("rand_overrun", {63'd0, overrun}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
